// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, TX state encoding and parity helper
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam int MAX_DBIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Data is zero-extended to MAX_DBIT by the caller; extra zeros leave the XOR unchanged.
    function automatic logic parity_of(input logic [1:0] mode, input logic [MAX_DBIT-1:0] data);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with full/empty flags and occupancy level
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with runtime parity and stop-bit selection
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_tick,
    input  logic [DBIT-1:0]               din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          tx,
    output logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DBIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    tx_state_t       state, state_n;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [DBIT-1:0] shift, shift_n;
    logic            par_en, par_bit, stop2_q;
    logic            tx_q, tx_n;
    logic            done_q, done_n;
    logic            pop, load, bit_end;

    logic [DBIT-1:0] fifo_rdata;
    logic            fifo_full, fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DBIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (din_valid),
        .wdata (din),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign din_ready = !fifo_full;
    assign busy      = (state != ST_IDLE);
    assign tx        = tx_q;
    assign tx_done   = done_q;
    assign bit_end   = s_tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        load    = 1'b0;
        done_n  = 1'b0;
        tx_n    = 1'b1;

        if (state != ST_IDLE && s_tick) begin
            tick_n = bit_end ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = ST_START;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            end
            ST_START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_n = shift[0];
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_n = par_bit;
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (stop2_q && bit_cnt == '0) begin
                        bit_n = BW'(1);
                    end else begin
                        // Chain straight into the next start bit when data is waiting.
                        done_n = 1'b1;
                        bit_n  = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) shift_n = fifo_rdata;
    end

    // tx follows the current state through a register, so it lags the state by one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
            if (load) begin
                par_en  <= (parity_mode != PAR_NONE);
                par_bit <= parity_of(parity_mode, MAX_DBIT'(fifo_rdata));
                stop2_q <= stop2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg against a tick-level line model
module tb_uart_tx_cfg;

    localparam int DBIT  = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_tick = 1'b0;
    logic [DBIT-1:0] din;
    logic            din_valid;
    logic            din_ready;
    logic [1:0]      parity_mode;
    logic            stop2;
    logic            tx;
    logic            tx_done;
    logic            busy;
    logic [LW-1:0]   fifo_level;

    int total = 0;
    int bad   = 0;
    int tick_mode = 0;

    bit got[$];
    int done_at[$];
    bit exp_q[$];
    int exp_done[$];
    bit pend = 1'b0;

    uart_tx_cfg #(.DBIT(DBIT), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .tx_done     (tx_done),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (tick_mode)
            0:       s_tick = 1'b0;
            1:       s_tick = 1'b1;
            default: s_tick = 1'($urandom_range(0, 1));
        endcase
    end

    // One line sample per counted tick: the level tx shows after that tick's edge.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) got.push_back(tx);
            if (tx_done) done_at.push_back(got.size());
            pend = s_tick && busy;
        end
    end

    task automatic add_frame(input logic [DBIT-1:0] d, input logic [1:0] mode, input logic s2);
        bit bits[$];
        int ones;
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) bits.push_back(d[i]);
        if (mode == 2'b01) bits.push_back((ones % 2) == 1);
        if (mode == 2'b10) bits.push_back((ones % 2) == 0);
        if (mode == 2'b11) bits.push_back(1'b1);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < OS; k++) exp_q.push_back(bits[i]);
        exp_done.push_back(exp_q.size());
    endtask

    task automatic clear_sb();
        got.delete();
        done_at.delete();
        exp_q.delete();
        exp_done.delete();
    endtask

    function automatic int stream_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int done_diff();
        int n;
        n = (done_at.size() < exp_done.size()) ? done_at.size() : exp_done.size();
        for (int i = 0; i < n; i++) if (done_at[i] != exp_done[i]) return i;
        if (done_at.size() != exp_done.size()) return n;
        return -1;
    endfunction

    task automatic wait_done(input int n, input int budget);
        int cyc = 0;
        while (done_at.size() < n && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DBIT-1:0] d, output bit ok);
        int cyc = 0;
        @(posedge clk); #1;
        din = d;
        din_valid = 1'b1;
        while (!din_ready && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = din_ready;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        din = '0;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (din_ready !== 1'b1)  begin bad++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
        total++; if (fifo_level !== '0)   begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (tx_done !== 1'b0)    begin bad++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        tick_mode = 0;
        repeat (2) @(posedge clk);
        clear_sb();
        #1;
        din = 8'h3C;
        din_valid = 1'b1;
        add_frame(8'h3C, parity_mode, stop2);
        @(posedge clk); #1;
        din_valid = 1'b0;
        total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL lat_level_n: got %0d want 1", fifo_level); end
        total++; if (tx !== 1'b1)           begin bad++; $display("FAIL lat_tx_n: got %b want 1", tx); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b1 || fifo_level !== '0) begin bad++; $display("FAIL lat_pop_n1: busy %b level %0d want 1/0", busy, fifo_level); end
        total++; if (tx !== 1'b1)           begin bad++; $display("FAIL lat_tx_n1: got %b want 1", tx); end
        @(posedge clk); #1;
        total++; if (tx !== 1'b0)           begin bad++; $display("FAIL lat_tx_n2: got %b want 0", tx); end
        tick_mode = 1;
        wait_done(1, 400);
        total++; if (stream_diff() != -1)   begin bad++; $display("FAIL lat_stream: mismatch at %0d of %0d want none", stream_diff(), exp_q.size()); end
    endtask

    task automatic test_basic_frame();
        bit ok;
        clear_sb();
        parity_mode = 2'b00;
        stop2 = 1'b0;
        tick_mode = 1;
        add_frame(8'h55, 2'b00, 1'b0);
        send_word(8'h55, ok);
        wait_done(1, 400);
        total++; if (got.size() != 160)    begin bad++; $display("FAIL basic_len: got %0d want 160", got.size()); end
        for (int b = 0; b < 10 && got.size() == 160; b++) begin
            total++;
            if (got[b*OS] !== 1'(b % 2)) begin bad++; $display("FAIL basic_bit%0d: got %b want %0d", b, got[b*OS], b % 2); end
        end
        total++; if (stream_diff() != -1)  begin bad++; $display("FAIL basic_stream: mismatch at %0d want none", stream_diff()); end
        total++; if (done_at.size() != 1 || (done_at.size() == 1 && done_at[0] != 160)) begin
            bad++; $display("FAIL basic_done: count %0d want single pulse at tick 160", done_at.size()); end
        total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL basic_idle: busy %b tx %b want 0/1", busy, tx); end
    endtask

    task automatic test_parity();
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
        bit         pbits [3] = '{1'b1, 1'b0, 1'b1};
        bit ok;
        for (int m = 0; m < 3; m++) begin
            clear_sb();
            parity_mode = modes[m];
            stop2 = 1'b0;
            tick_mode = 2;
            add_frame(8'h07, modes[m], 1'b0);
            send_word(8'h07, ok);
            wait_done(1, 2000);
            total++; if (got.size() != 176) begin bad++; $display("FAIL par%0d_len: got %0d want 176", m, got.size()); end
            total++; if (got.size() != 176 || got[OS*9] !== pbits[m]) begin
                bad++; $display("FAIL par%0d_bit: got %b want %b", m, (got.size() > OS*9) ? got[OS*9] : 1'bx, pbits[m]); end
            total++; if (stream_diff() != -1) begin bad++; $display("FAIL par%0d_stream: mismatch at %0d want none", m, stream_diff()); end
        end
    endtask

    task automatic test_stop2();
        bit ok;
        int zeros = 0;
        clear_sb();
        parity_mode = 2'b00;
        stop2 = 1'b1;
        tick_mode = 1;
        add_frame(8'hA3, 2'b00, 1'b1);
        send_word(8'hA3, ok);
        wait_done(1, 400);
        total++; if (done_diff() != -1 || done_at.size() != 1 || done_at[0] != 176) begin
            bad++; $display("FAIL stop2_done: count %0d want one pulse at tick 176", done_at.size()); end
        total++; if (stream_diff() != -1) begin bad++; $display("FAIL stop2_stream: mismatch at %0d want none", stream_diff()); end
        repeat (40) begin @(negedge clk); if (tx !== 1'b1) zeros++; end
        total++; if (zeros != 0 || busy !== 1'b0) begin bad++; $display("FAIL stop2_after: low cycles %0d busy %b want 0/0", zeros, busy); end
        stop2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DBIT-1:0] words [6];
        int acc = 0;
        int idle_cyc = 0;
        int cyc = 0;
        bit r6 = 1'b1;
        clear_sb();
        parity_mode = 2'($urandom_range(0, 3));
        stop2 = 1'($urandom_range(0, 1));
        tick_mode = 0;
        for (int i = 0; i < 6; i++) words[i] = DBIT'($urandom);
        repeat (2) @(posedge clk);
        #1;
        din_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            din = words[acc];
            if (c == 5) r6 = din_ready;
            if (din_ready) begin
                add_frame(words[acc], parity_mode, stop2);
                acc++;
            end
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        total++; if (acc != 5)             begin bad++; $display("FAIL b2b_accepted: got %0d want 5", acc); end
        total++; if (r6 !== 1'b0)          begin bad++; $display("FAIL b2b_ready6: got %b want 0", r6); end
        total++; if (fifo_level !== LW'(4)) begin bad++; $display("FAIL b2b_level: got %0d want 4", fifo_level); end
        tick_mode = 1;
        while (done_at.size() < 5 && cyc < 5000) begin
            @(negedge clk); #1;
            if (!busy && done_at.size() < 5) idle_cyc++;
            cyc++;
        end
        repeat (2) @(negedge clk);
        total++; if (done_at.size() != 5) begin bad++; $display("FAIL b2b_timeout: tx_done count %0d want 5", done_at.size()); end
        total++; if (idle_cyc != 0)       begin bad++; $display("FAIL b2b_gap: idle cycles %0d want 0", idle_cyc); end
        total++; if (stream_diff() != -1) begin bad++; $display("FAIL b2b_stream: mismatch at %0d want none", stream_diff()); end
        total++; if (done_diff() != -1)   begin bad++; $display("FAIL b2b_done: mismatch at pulse %0d want none", done_diff()); end
    endtask

    task automatic test_cfg_change();
        bit ok;
        int cyc = 0;
        clear_sb();
        parity_mode = 2'b00;
        stop2 = 1'b0;
        tick_mode = 0;
        repeat (2) @(posedge clk);
        add_frame(8'hC9, 2'b00, 1'b0);
        add_frame(8'h5E, 2'b10, 1'b0);
        send_word(8'hC9, ok);
        send_word(8'h5E, ok);
        tick_mode = 1;
        while (got.size() < 40 && cyc < 400) begin @(negedge clk); #1; cyc++; end
        parity_mode = 2'b10;
        wait_done(2, 1000);
        total++; if (done_at.size() != 2 || done_at[0] != 160) begin
            bad++; $display("FAIL cfg_first_len: pulses %0d first %0d want 2/160", done_at.size(), done_at.size() > 0 ? done_at[0] : -1); end
        total++; if (stream_diff() != -1) begin bad++; $display("FAIL cfg_stream: mismatch at %0d want none", stream_diff()); end
        parity_mode = 2'b00;
    endtask

    task automatic test_random();
        bit ok;
        logic [DBIT-1:0] d;
        for (int it = 0; it < 6; it++) begin
            clear_sb();
            d = DBIT'($urandom);
            parity_mode = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            tick_mode = $urandom_range(1, 2);
            add_frame(d, parity_mode, stop2);
            send_word(d, ok);
            wait_done(1, 2000);
            total++; if (stream_diff() != -1 || done_diff() != -1) begin
                bad++; $display("FAIL rand%0d: data %h mode %0d stop2 %b stream diff %0d done diff %0d want none",
                                it, d, parity_mode, stop2, stream_diff(), done_diff()); end
        end
        stop2 = 1'b0;
        parity_mode = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc = 0;
        int lows = 0;
        clear_sb();
        tick_mode = 0;
        repeat (2) @(posedge clk);
        send_word(8'hE1, ok);
        send_word(8'h1E, ok);
        send_word(8'h99, ok);
        tick_mode = 1;
        while (got.size() < 40 && cyc < 400) begin @(negedge clk); #1; cyc++; end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (fifo_level !== '0 || din_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_fifo: level %0d ready %b want 0/1", fifo_level, din_ready); end
        done_at.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (300) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) lows++; end
        total++; if (done_at.size() != 0 || lows != 0) begin
            bad++; $display("FAIL rst_mid_after: tx_done %0d active cycles %0d want 0/0", done_at.size(), lows); end
    endtask

    initial begin
        din_valid = 1'b0;
        din = '0;
        reset = 1'b1;
        test_reset();
        test_latency();
        test_basic_frame();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_cfg_change();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
